// File: rtl/display_pkg.sv
// Constants and controller state encoding shared by the display adapter's
// read-side and write-side controllers.
package display_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned ADDR_W   = 20;
    localparam int unsigned PX_W     = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Two-entry synchronous FIFO that holds {address, pixel} write requests while
// the memory arbiter withholds the write port.
module fb_wr_fifo #(
    parameter int unsigned WIDTH = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count_q != 2'd2);
    assign do_pop  = pop && (count_q != 2'd0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fb_writer.sv
// Frame-buffer writer: accepts a host pixel stream, tracks the write position
// and stores pixels into frame memory whenever the arbiter grants the port.
module fb_writer #(
    parameter int unsigned H_ACTIVE = display_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE = display_pkg::V_ACTIVE,
    parameter int unsigned ADDR_W   = display_pkg::ADDR_W,
    parameter int unsigned PX_W     = display_pkg::PX_W
) (
    input  logic              clk,
    input  logic              ResetN,
    input  logic              Start,
    input  logic              PxValid,
    input  logic [PX_W-1:0]   PxData,
    input  logic              PxSof,
    output logic              PxReady,
    input  logic              MemGrant,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [PX_W-1:0]   MemData,
    output logic [9:0]        PxOut,
    output logic [9:0]        LineOut,
    output logic              FrameDone,
    output logic              SyncErr
);
    import display_pkg::*;

    localparam int unsigned FifoW = ADDR_W + PX_W;

    ctrl_state_e       state_q, state_d;
    logic [9:0]        px_q, px_d;
    logic [9:0]        line_q, line_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sync_err_q, sync_err_d;
    logic [1:0]        fifo_count;
    logic [FifoW-1:0]  fifo_head;
    logic              accept;
    logic              sof_err;
    logic              mem_pop;
    logic [9:0]        cur_px;
    logic [9:0]        cur_line;
    logic [ADDR_W-1:0] cur_addr;
    logic              last_px;

    assign PxReady = (state_q == StWrite) && (fifo_count < 2'd2);
    assign accept  = PxValid && PxReady;
    assign sof_err = accept && PxSof && ((px_q != 10'd0) || (line_q != 10'd0));

    // A misplaced SOF pixel is written as if it were pixel (0,0) of a new frame.
    assign cur_px   = sof_err ? 10'd0 : px_q;
    assign cur_line = sof_err ? 10'd0 : line_q;
    assign cur_addr = sof_err ? '0 : addr_q;
    assign last_px  = (cur_px == 10'(H_ACTIVE - 1)) && (cur_line == 10'(V_ACTIVE - 1));

    assign mem_pop            = MemGrant && (fifo_count != 2'd0);
    assign MemWe              = mem_pop;
    assign {MemAddr, MemData} = fifo_head;
    assign PxOut              = px_q;
    assign LineOut            = line_q;
    assign FrameDone          = (state_q == StDone);
    assign SyncErr            = sync_err_q;

    fb_wr_fifo #(
        .WIDTH(FifoW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (ResetN),
        .push     (accept),
        .push_data({cur_addr, PxData}),
        .pop      (mem_pop),
        .count    (fifo_count),
        .head     (fifo_head)
    );

    always_comb begin
        state_d    = state_q;
        px_d       = px_q;
        line_d     = line_q;
        addr_d     = addr_q;
        sync_err_d = sync_err_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d    = StWrite;
                    px_d       = 10'd0;
                    line_d     = 10'd0;
                    addr_d     = '0;
                    sync_err_d = 1'b0;
                end
            end
            StWrite: begin
                if (accept) begin
                    if (sof_err) begin
                        sync_err_d = 1'b1;
                    end
                    addr_d = cur_addr + ADDR_W'(1);
                    if (cur_px == 10'(H_ACTIVE - 1)) begin
                        px_d   = 10'd0;
                        line_d = (cur_line == 10'(V_ACTIVE - 1)) ? 10'd0 : cur_line + 10'd1;
                    end else begin
                        px_d   = cur_px + 10'd1;
                        line_d = cur_line;
                    end
                    if (last_px) begin
                        state_d = StDrain;
                        addr_d  = '0;
                    end
                end
            end
            StDrain: begin
                // Leave once the final buffered pixel is popped at this edge.
                if ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && mem_pop)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!ResetN) begin
            state_q    <= StIdle;
            px_q       <= 10'd0;
            line_q     <= 10'd0;
            addr_q     <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            px_q       <= px_d;
            line_q     <= line_d;
            addr_q     <= addr_d;
            sync_err_q <= sync_err_d;
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Directed self-checking bench for fb_writer on a 4x3 frame.
module tb_fb_writer;
    localparam int unsigned H  = 4;
    localparam int unsigned V  = 3;
    localparam int unsigned AW = 20;
    localparam int unsigned PW = 8;

    logic          clk = 1'b0;
    logic          ResetN, Start, PxValid, PxSof, PxReady, MemGrant, MemWe, FrameDone, SyncErr;
    logic [PW-1:0] PxData, MemData;
    logic [AW-1:0] MemAddr;
    logic [9:0]    PxOut, LineOut;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd_count = 0;
    int fd_cyc = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];

    always #5 clk = ~clk;

    fb_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .PX_W(PW)) dut (
        .clk(clk), .ResetN(ResetN), .Start(Start), .PxValid(PxValid), .PxData(PxData),
        .PxSof(PxSof), .PxReady(PxReady), .MemGrant(MemGrant), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemData(MemData), .PxOut(PxOut), .LineOut(LineOut),
        .FrameDone(FrameDone), .SyncErr(SyncErr)
    );

    // Memory-side log, sampled mid-cycle ahead of the write edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (MemWe) begin
            wr_addr.push_back(int'(MemAddr));
            wr_data.push_back(int'(MemData));
            wr_cyc.push_back(cyc);
        end
        if (FrameDone) begin
            fd_count <= fd_count + 1;
            fd_cyc   <= cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic send_pixels(input int first, input int n, input int sof_idx);
        int   sent;
        int   t;
        logic rdy;
        sent = 0;
        t    = 0;
        while (sent < n && t < 20 * n + 20) begin
            PxValid = 1'b1;
            PxData  = PW'(first + sent);
            PxSof   = (first + sent == sof_idx);
            #1;
            rdy = PxReady;
            tick();
            if (rdy) sent++;
            t++;
        end
        PxValid = 1'b0;
        PxSof   = 1'b0;
        checks++;
        if (sent !== n) begin
            errors++;
            $display("FAIL send_pixels: accepted %0d required %0d", sent, n);
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!FrameDone && t < 60) begin
            tick();
            t++;
        end
        checks++;
        if (FrameDone !== 1'b1) begin
            errors++;
            $display("FAIL frame_done_timeout: got %b required 1", FrameDone);
        end
    endtask

    task automatic test_reset();
        ResetN = 1'b0; Start = 1'b0; PxValid = 1'b0; PxSof = 1'b0; PxData = '0; MemGrant = 1'b1;
        tick();
        tick();
        checks += 8;
        if (PxReady !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", PxReady); end
        if (MemWe !== 1'b0) begin errors++; $display("FAIL reset_we: got %b required 0", MemWe); end
        if (MemAddr !== '0) begin errors++; $display("FAIL reset_addr: got %0d required 0", MemAddr); end
        if (MemData !== '0) begin errors++; $display("FAIL reset_data: got %0d required 0", MemData); end
        if (PxOut !== 10'd0) begin errors++; $display("FAIL reset_px: got %0d required 0", PxOut); end
        if (LineOut !== 10'd0) begin errors++; $display("FAIL reset_line: got %0d required 0", LineOut); end
        if (FrameDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", FrameDone); end
        if (SyncErr !== 1'b0) begin errors++; $display("FAIL reset_syncerr: got %b required 0", SyncErr); end
        ResetN   = 1'b1;
        MemGrant = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int b, fb;
        b  = wr_addr.size();
        fb = fd_count;
        MemGrant = 1'b1;
        pulse_start();
        checks++;
        if (PxReady !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b required 1", PxReady); end
        send_pixels(0, 12, 0);
        wait_done();
        repeat (3) tick();
        checks++;
        if (wr_addr.size() - b !== 12) begin
            errors++; $display("FAIL basic_count: got %0d required 12", wr_addr.size() - b);
        end
        if (wr_addr.size() >= b + 12) begin
            for (int i = 0; i < 12; i++) begin
                checks += 3;
                if (wr_addr[b+i] !== i) begin errors++; $display("FAIL basic_addr[%0d]: got %0d required %0d", i, wr_addr[b+i], i); end
                if (wr_data[b+i] !== i) begin errors++; $display("FAIL basic_data[%0d]: got %0d required %0d", i, wr_data[b+i], i); end
                if (wr_cyc[b+i] !== wr_cyc[b] + i) begin errors++; $display("FAIL basic_consecutive[%0d]: got %0d required %0d", i, wr_cyc[b+i], wr_cyc[b] + i); end
            end
            checks++;
            if (fd_cyc !== wr_cyc[b+11] + 1) begin errors++; $display("FAIL basic_done_cycle: got %0d required %0d", fd_cyc, wr_cyc[b+11] + 1); end
        end
        checks += 2;
        if (fd_count - fb !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d required 1", fd_count - fb); end
        if (SyncErr !== 1'b0) begin errors++; $display("FAIL basic_syncerr: got %b required 0", SyncErr); end
    endtask

    task automatic test_line_wrap();
        int b;
        b = wr_addr.size();
        MemGrant = 1'b1;
        pulse_start();
        send_pixels(0, 3, 0);
        checks += 2;
        if (PxOut !== 10'd3) begin errors++; $display("FAIL wrap_px_before: got %0d required 3", PxOut); end
        if (LineOut !== 10'd0) begin errors++; $display("FAIL wrap_line_before: got %0d required 0", LineOut); end
        send_pixels(3, 1, -1);
        checks += 2;
        if (PxOut !== 10'd0) begin errors++; $display("FAIL wrap_px_after: got %0d required 0", PxOut); end
        if (LineOut !== 10'd1) begin errors++; $display("FAIL wrap_line_after: got %0d required 1", LineOut); end
        send_pixels(4, 8, -1);
        wait_done();
        repeat (2) tick();
        checks++;
        if (wr_addr.size() < b + 5 || wr_addr[b+4] !== 4 || wr_data[b+4] !== 4) begin
            errors++; $display("FAIL wrap_addr4: writes %0d, fifth write not addr 4 data 4", wr_addr.size() - b);
        end
    endtask

    task automatic test_grant_stall();
        int   b, nb, acc;
        logic rdy, ready_late;
        b = wr_addr.size();
        MemGrant = 1'b1;
        pulse_start();
        send_pixels(0, 5, 0);
        tick();
        nb = wr_addr.size();
        MemGrant   = 1'b0;
        acc        = 0;
        ready_late = 1'b0;
        for (int c = 0; c < 5; c++) begin
            PxValid = 1'b1;
            PxData  = PW'(5 + acc);
            PxSof   = 1'b0;
            #1;
            rdy = PxReady;
            if (c >= 2 && rdy) ready_late = 1'b1;
            tick();
            if (rdy) acc++;
        end
        PxValid = 1'b0;
        checks += 3;
        if (acc !== 2) begin errors++; $display("FAIL stall_accepts: got %0d required 2", acc); end
        if (ready_late !== 1'b0) begin errors++; $display("FAIL stall_ready_drop: ready seen while full"); end
        if (wr_addr.size() !== nb) begin errors++; $display("FAIL stall_no_we: got %0d writes required 0", wr_addr.size() - nb); end
        MemGrant = 1'b1;
        send_pixels(7, 5, -1);
        wait_done();
        repeat (2) tick();
        checks++;
        if (wr_addr.size() - b !== 12) begin errors++; $display("FAIL stall_count: got %0d required 12", wr_addr.size() - b); end
        if (wr_addr.size() >= b + 12) begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (wr_addr[b+i] !== i || wr_data[b+i] !== i) begin
                    errors++; $display("FAIL stall_image[%0d]: got addr %0d data %0d required %0d", i, wr_addr[b+i], wr_data[b+i], i);
                end
            end
        end
    endtask

    task automatic test_sof();
        int b, fb;
        b  = wr_addr.size();
        fb = fd_count;
        MemGrant = 1'b1;
        pulse_start();
        send_pixels(0, 6, 5);
        checks++;
        if (SyncErr !== 1'b1) begin errors++; $display("FAIL sof_syncerr: got %b required 1", SyncErr); end
        send_pixels(6, 10, -1);
        repeat (3) tick();
        checks++;
        if (fd_count !== fb) begin errors++; $display("FAIL sof_early_done: got %0d pulses required 0", fd_count - fb); end
        send_pixels(16, 1, -1);
        wait_done();
        repeat (2) tick();
        checks += 3;
        if (wr_addr.size() - b !== 17) begin errors++; $display("FAIL sof_count: got %0d required 17", wr_addr.size() - b); end
        if (SyncErr !== 1'b1) begin errors++; $display("FAIL sof_sticky: got %b required 1", SyncErr); end
        if (fd_count - fb !== 1) begin errors++; $display("FAIL sof_done_pulses: got %0d required 1", fd_count - fb); end
        if (wr_addr.size() >= b + 17) begin
            checks += 2;
            if (wr_addr[b+5] !== 0 || wr_data[b+5] !== 5) begin
                errors++; $display("FAIL sof_realign: got addr %0d data %0d required addr 0 data 5", wr_addr[b+5], wr_data[b+5]);
            end
            if (wr_addr[b+16] !== 11 || wr_data[b+16] !== 16) begin
                errors++; $display("FAIL sof_last: got addr %0d data %0d required addr 11 data 16", wr_addr[b+16], wr_data[b+16]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int b, b2;
        b = wr_addr.size();
        MemGrant = 1'b1;
        pulse_start();
        checks++;
        if (SyncErr !== 1'b0) begin errors++; $display("FAIL b2b_syncerr_clear: got %b required 0", SyncErr); end
        send_pixels(0, 6, 0);
        pulse_start();
        checks += 3;
        if (PxOut !== 10'd2) begin errors++; $display("FAIL b2b_ignored_px: got %0d required 2", PxOut); end
        if (LineOut !== 10'd1) begin errors++; $display("FAIL b2b_ignored_line: got %0d required 1", LineOut); end
        if (PxReady !== 1'b1) begin errors++; $display("FAIL b2b_ignored_ready: got %b required 1", PxReady); end
        send_pixels(6, 6, -1);
        wait_done();
        b2 = wr_addr.size();
        tick();
        pulse_start();
        checks += 2;
        if (PxReady !== 1'b1) begin errors++; $display("FAIL b2b_restart_ready: got %b required 1", PxReady); end
        if (b2 - b !== 12) begin errors++; $display("FAIL b2b_first_count: got %0d required 12", b2 - b); end
        send_pixels(50, 12, 50);
        wait_done();
        repeat (2) tick();
        checks++;
        if (wr_addr.size() - b2 !== 12) begin errors++; $display("FAIL b2b_second_count: got %0d required 12", wr_addr.size() - b2); end
        if (wr_addr.size() >= b2 + 12) begin
            checks += 2;
            if (wr_addr[b2] !== 0 || wr_data[b2] !== 50) begin
                errors++; $display("FAIL b2b_second_first: got addr %0d data %0d required addr 0 data 50", wr_addr[b2], wr_data[b2]);
            end
            if (wr_addr[b+6] !== 6 || wr_data[b+6] !== 6) begin
                errors++; $display("FAIL b2b_continue: got addr %0d data %0d required addr 6 data 6", wr_addr[b+6], wr_data[b+6]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int nb;
        MemGrant = 1'b1;
        pulse_start();
        send_pixels(0, 3, 0);
        MemGrant = 1'b0;
        send_pixels(3, 1, -1);
        checks++;
        if (PxReady !== 1'b0) begin errors++; $display("FAIL rmid_full: got %b required 0", PxReady); end
        nb = wr_addr.size();
        ResetN = 1'b0;
        tick();
        checks += 7;
        if (MemWe !== 1'b0) begin errors++; $display("FAIL rmid_we: got %b required 0", MemWe); end
        if (PxReady !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b required 0", PxReady); end
        if (MemAddr !== '0) begin errors++; $display("FAIL rmid_addr: got %0d required 0", MemAddr); end
        if (MemData !== '0) begin errors++; $display("FAIL rmid_data: got %0d required 0", MemData); end
        if (PxOut !== 10'd0) begin errors++; $display("FAIL rmid_px: got %0d required 0", PxOut); end
        if (LineOut !== 10'd0) begin errors++; $display("FAIL rmid_line: got %0d required 0", LineOut); end
        if (FrameDone !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b required 0", FrameDone); end
        ResetN   = 1'b1;
        MemGrant = 1'b1;
        repeat (3) tick();
        checks++;
        if (wr_addr.size() !== nb) begin errors++; $display("FAIL rmid_discard: got %0d writes required 0", wr_addr.size() - nb); end
        pulse_start();
        send_pixels(20, 12, 20);
        wait_done();
        repeat (2) tick();
        checks++;
        if (wr_addr.size() < nb + 12 || wr_addr[nb] !== 0 || wr_data[nb] !== 20) begin
            errors++; $display("FAIL rmid_restart: writes %0d, first not addr 0 data 20", wr_addr.size() - nb);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_line_wrap();
        test_grant_stall();
        test_sof();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_writer.md
# fb_writer

Frame-buffer writer for the display adapter: the write-side counterpart of the display read path, which scans frame memory with its pixel, line and address counters. It accepts a host pixel stream over a valid/ready handshake and tracks write position as pixel/line counters. It generates linear write addresses and stores pixels into the shared frame memory whenever the memory arbiter grants the write port. A 2-entry buffer absorbs grant loss, so the source is never dropped.

## Interface
Parameters:
- `H_ACTIVE`, 640: pixels per line.
- `V_ACTIVE`, 480: lines per frame.
- `ADDR_W`, 20: memory address width; H_ACTIVE*V_ACTIVE ≤ 2^ADDR_W.
- `PX_W`, 8: pixel data width.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `ResetN` in 1: synchronous, active-low reset.
- `Start` in 1: one-cycle pulse that begins a frame. Honoured only in IDLE.
- `PxValid` in 1: source pixel valid.
- `PxData` in PX_W: source pixel.
- `PxSof` in 1: start-of-frame marker, qualified by PxValid.
- `PxReady` out 1: writer accepts this cycle.
- `MemGrant` in 1: arbiter grants the write port this cycle.
- `MemWe` out 1: write strobe.
- `MemAddr` out ADDR_W: write address.
- `MemData` out PX_W: write data.
- `PxOut` out 10: pixel index of the next accepted pixel.
- `LineOut` out 10: line index of the next accepted pixel.
- `FrameDone` out 1: one-cycle pulse when the last pixel has been written.
- `SyncErr` out 1: sticky flag for misplaced SOF. Cleared by Start or reset.

## Operation
- **FSM states:** IDLE, WRITE, DRAIN, DONE.
- **IDLE:**
  - PxReady=0.
  - Start=1 → clear PxOut/LineOut/address counter/SyncErr, go to WRITE.
- **WRITE:**
  - PxReady = (fifo count < 2). There is no pass-through when full, even if a pop occurs in the same cycle.
  - Accept = PxValid & PxReady. Each accept pushes {address, PxData}.
  - After an accept, PxOut increments. At H_ACTIVE-1 it wraps to 0 and LineOut increments.
  - The address counter increments by 1 per accept (no multiply).
  - Accept of pixel (H_ACTIVE-1, V_ACTIVE-1) → go to DRAIN. PxReady=0 from the next cycle.
- **SOF handling:**
  - Accept with PxSof=1 while position ≠ (0,0) → SyncErr←1.
  - That pixel is realigned: it is written at address 0 and the counters restart as if it were pixel (0,0).
  - PxSof=1 at (0,0) is normal.
  - PxSof=0 at (0,0) is accepted without error.
- **DRAIN:**
  - PxReady=0.
  - When the fifo becomes empty (after the final pop) → DONE.
- **DONE:** FrameDone=1 for exactly one cycle → IDLE.
- **Memory side (all states):**
  - MemWe = fifo non-empty & MemGrant.
  - MemAddr/MemData = fifo head; the write occurs at that edge and the head is popped.
  - MemGrant low → hold. MemWe=0 and the head stays unchanged.
  - Push and pop in the same cycle are both honoured. The count is unchanged.
- Start outside IDLE is ignored.
- Counters never exceed H_ACTIVE-1 / V_ACTIVE-1.

## Timing
- Reset values: state IDLE, PxReady 0, MemWe 0, MemAddr 0, MemData 0, PxOut 0, LineOut 0, FrameDone 0, SyncErr 0, fifo empty.
- ResetN low mid-frame → everything above at the next edge. Buffered pixels are discarded, not written.
- Start at edge N → PxReady can be 1 in cycle N+1.
- Latency: pixel accepted at edge N appears on MemWe/MemAddr/MemData in cycle N+1 if the fifo was empty and MemGrant=1.
- Sustained throughput: 1 pixel/cycle with MemGrant held high.
- Grant loss: at most 2 pixels are buffered, then PxReady drops combinationally from fifo count (registered state only).
- FrameDone asserts the cycle after the final write edge.

## Structure
- **Shared package `display_pkg`:**
  - constants H_ACTIVE, V_ACTIVE, ADDR_W, PX_W;
  - FSM state encoding (IDLE=0, WRITE=1, DRAIN=2, DONE=3), also used by the read-side controller.
- **Sub-module `fb_wr_fifo`:** 2-entry synchronous FIFO of {ADDR_W+PX_W} bits.
  - push/pop/count/head;
  - same-cycle push+pop allowed;
  - synchronous active-low reset.
- **fb_writer body:** FSM, position counters, address counter, SOF check.

## Test plan
Use H_ACTIVE=4, V_ACTIVE=3 unless noted.
- **Basic frame:**
  - Stimulus: Start, MemGrant=1, PxValid=1 with data 0..11.
  - Required: MemAddr 0..11 match data in order on consecutive cycles. FrameDone pulses once, one cycle after the write of addr 11. SyncErr=0.
- **Grant stall:**
  - Stimulus: MemGrant=0 for 5 cycles mid-line.
  - Required: PxReady drops after 2 accepts. No MemWe during the stall. After grant returns, the writes resume with no loss or duplication. The final memory image equals 0..11.
- **Line wrap:**
  - Required: after pixel 3, PxOut=0 and LineOut=1. Address 4 is used for the next pixel.
- **Misplaced SOF:**
  - Stimulus: PxSof on the 6th pixel.
  - Required: SyncErr=1 and stays 1. That pixel is written at address 0. 12 more pixels are needed before FrameDone.
- **Reset mid-frame:**
  - Stimulus: ResetN=0 with 2 pixels buffered and MemGrant=0.
  - Required: no further MemWe. All outputs hold reset values. Start afterwards begins at address 0.
- **Start ignored and back-to-back frames:**
  - Stimulus: Start pulse during WRITE, then Start the cycle after FrameDone.
  - Required: the pulse during WRITE has no effect. The second frame restarts at address 0.
